// File: rtl/sensor_event_fifo_if.sv
// Avalon-MM bus between the HPS bridge (master) and the sensor event FIFO (slave).
// Zero-wait slave: readdata is combinational from address, waitrequest is tied low.
interface sensor_event_fifo_if;
    logic [1:0]  address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        waitrequest;

    modport master (
        output address, read, write, writedata,
        input  readdata, waitrequest
    );

    modport slave (
        input  address, read, write, writedata,
        output readdata, waitrequest
    );
endinterface

// File: rtl/sensor_event_fifo.sv
// Sensor event FIFO.
// Watches every lighthouse decoder's data_available level for a rising edge,
// latches that channel's 32-bit value into a holding register, arbitrates the
// pending captures round-robin (one grant per cycle) and pushes {id, value}
// into a single FIFO that software drains through a zero-wait Avalon slave.
//
// Register map (word addresses):
//   0  status     [31] overflow, [23:16] level, [ID_W-1:0] head id (0 when empty)
//   1  head value reading pops; empty returns 32'hDEAD_BEEF without popping
//   2  drops      {16'h0, drop_count}, saturating
//   3  config     read {16'h0, NUM_SENSORS, DEPTH}; write bit0 clears overflow/drops
module sensor_event_fifo #(
    parameter int NUM_SENSORS = 16,
    parameter int DEPTH       = 32,
    parameter int ID_W        = 4
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic [NUM_SENSORS*32-1:0] sensor_value,
    input  logic [NUM_SENSORS-1:0]    data_available,
    sensor_event_fifo_if.slave        bus,
    output logic                      irq
);

    localparam int PTR_W   = $clog2(DEPTH);
    localparam int LEVEL_W = PTR_W + 1;
    localparam int ENTRY_W = ID_W + 32;
    localparam logic [31:0]        EMPTY_VALUE = 32'hDEAD_BEEF;
    localparam logic [LEVEL_W-1:0] FULL_LEVEL  = LEVEL_W'(DEPTH);

    // Saturating add for the drop counter; several drops can land in one cycle.
    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [5:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {11'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    // Wrap a channel index that may exceed NUM_SENSORS by less than NUM_SENSORS.
    function automatic logic [ID_W-1:0] wrap_idx(input int sum);
        return ID_W'((sum >= NUM_SENSORS) ? sum - NUM_SENSORS : sum);
    endfunction

    // Capture stage state
    logic [NUM_SENSORS-1:0] prev_avail;
    logic [NUM_SENSORS-1:0] pending;
    logic [31:0]            holding [NUM_SENSORS];
    logic [ID_W-1:0]        rr_ptr;

    // FIFO state
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LEVEL_W-1:0] level;

    // Error bookkeeping
    logic        overflow;
    logic [15:0] drop_count;

    // Combinational control
    logic [NUM_SENSORS-1:0] rise;
    logic                   grant_vld;
    logic [ID_W-1:0]        grant_id;
    logic [NUM_SENSORS-1:0] grant_onehot;
    logic [NUM_SENSORS-1:0] capture_drop;
    logic                   pop;
    logic                   push;
    logic                   push_drop;
    logic [5:0]             n_drops;
    logic                   clear_req;
    logic [ENTRY_W-1:0]     head_entry;
    logic [ID_W-1:0]        head_id;
    logic [31:0]            head_value;
    logic [7:0]             level_byte;
    logic                   unused_writedata;

    assign rise = data_available & ~prev_avail;

    // Round-robin search of pending[], starting at rr_ptr and wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_id  = '0;
        for (int k = 0; k < NUM_SENSORS; k++) begin
            if (!grant_vld && pending[wrap_idx(int'(rr_ptr) + k)]) begin
                grant_vld = 1'b1;
                grant_id  = wrap_idx(int'(rr_ptr) + k);
            end
        end
    end

    assign grant_onehot = grant_vld ? (NUM_SENSORS'(1) << grant_id) : '0;

    // A full FIFO still accepts the grant when software pops in the same cycle.
    assign pop       = bus.read && (bus.address == 2'd1) && (level != '0);
    assign push      = grant_vld && ((level != FULL_LEVEL) || pop);
    assign push_drop = grant_vld && !push;

    // A fresh edge overwrites an un-granted pending value; a granted channel's
    // old value is pushed this cycle, so its new edge is not a loss.
    assign capture_drop = rise & pending & ~grant_onehot;

    // Total losses this cycle: overwritten captures plus a rejected push.
    always_comb begin
        n_drops = {5'b0, push_drop};
        for (int i = 0; i < NUM_SENSORS; i++) begin
            n_drops = n_drops + {5'b0, capture_drop[i]};
        end
    end

    assign clear_req = bus.write && (bus.address == 2'd3) && bus.writedata[0];
    assign unused_writedata = ^bus.writedata[31:1];

    // Edge history, holding registers, pending flags and round-robin pointer.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            prev_avail <= '0;
            pending    <= '0;
            rr_ptr     <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                holding[i] <= '0;
            end
        end else begin
            prev_avail <= data_available;
            pending    <= (pending & ~grant_onehot) | rise;
            for (int i = 0; i < NUM_SENSORS; i++) begin
                if (rise[i]) begin
                    holding[i] <= sensor_value[32*i +: 32];
                end
            end
            if (grant_vld) begin
                rr_ptr <= wrap_idx(int'(grant_id) + 1);
            end
        end
    end

    // FIFO storage; contents are don't-care until the pointers say otherwise.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {grant_id, holding[grant_id]};
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Overflow flag and drop counter; a drop in the clearing cycle wins.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (n_drops != '0) begin
            overflow   <= 1'b1;
            drop_count <= sat_add(clear_req ? 16'h0000 : drop_count, n_drops);
        end else if (clear_req) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end
    end

    assign head_entry = mem[rd_ptr];
    assign head_id    = (level != '0) ? head_entry[ENTRY_W-1:32] : '0;
    assign head_value = (level != '0) ? head_entry[31:0] : EMPTY_VALUE;
    assign level_byte = 8'(level);

    // Register read mux, combinational from address.
    always_comb begin
        case (bus.address)
            2'd0:    bus.readdata = {overflow, 7'b0, level_byte, {(16-ID_W){1'b0}}, head_id};
            2'd1:    bus.readdata = head_value;
            2'd2:    bus.readdata = {16'h0000, drop_count};
            default: bus.readdata = {16'h0000, 8'(NUM_SENSORS), 8'(DEPTH)};
        endcase
    end

    assign bus.waitrequest = 1'b0;
    assign irq             = (level != '0);

endmodule

// File: tb/tb_sensor_event_fifo.sv
// Self-checking bench for sensor_event_fifo: register-map table after reset,
// a table of single-channel events, and hand-written multi-cycle sequences.
// Expected FIFO contents are pushed to a scoreboard queue as edges are driven
// and compared as software pops them.
module tb_sensor_event_fifo;
    localparam int N     = 16;
    localparam int DEPTH = 32;

    logic            clock = 1'b0;
    logic            reset_n = 1'b0;
    logic [N*32-1:0] sensor_value = '0;
    logic [N-1:0]    data_available = '0;
    logic            irq;

    sensor_event_fifo_if bus();

    sensor_event_fifo #(.NUM_SENSORS(N), .DEPTH(DEPTH), .ID_W(4)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .sensor_value   (sensor_value),
        .data_available (data_available),
        .bus            (bus),
        .irq            (irq)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [3:0]  id;
        logic [31:0] value;
    } entry_t;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] exp;
    } reg_vec_t;

    typedef struct {
        int          ch;
        logic [31:0] value;
    } single_t;

    entry_t exp_q[$];
    int     checks   = 0;
    int     failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic peek(input logic [1:0] a, output logic [31:0] d);
        bus.address = a;
        bus.read    = 1'b0;
        #1;
        d = bus.readdata;
    endtask

    task automatic set_val(input int ch, input logic [31:0] v);
        sensor_value[32*ch +: 32] = v;
    endtask

    task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
        bus.address   = a;
        bus.writedata = d;
        bus.write     = 1'b1;
        tick();
        bus.write     = 1'b0;
        bus.writedata = '0;
    endtask

    task automatic pop_check(input string name);
        entry_t      e;
        logic [31:0] d;
        if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: scoreboard empty, got nothing expected an entry", name);
            return;
        end
        e = exp_q.pop_front();
        peek(2'd0, d);
        check({name, " head id"}, {28'h0, d[3:0]}, {28'h0, e.id});
        bus.address = 2'd1;
        bus.read    = 1'b1;
        #1;
        check({name, " value"}, bus.readdata, e.value);
        tick();
        bus.read = 1'b0;
    endtask

    task automatic drain(input string name);
        logic [31:0] d;
        while (exp_q.size() > 0) begin
            pop_check(name);
        end
        peek(2'd0, d);
        check({name, " drained level"}, {24'h0, d[23:16]}, 32'h0);
        check({name, " drained irq"}, {31'h0, irq}, 32'h0);
    endtask

    task automatic do_reset();
        reset_n        = 1'b0;
        data_available = '0;
        tick();
        tick();
        reset_n = 1'b1;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reg_vec_t    reg_tbl[4];
        single_t     sing[4];
        logic [31:0] d;
        entry_t      e;

        reg_tbl = '{
            '{2'd0, 32'h0000_0000},
            '{2'd1, 32'hDEAD_BEEF},
            '{2'd2, 32'h0000_0000},
            '{2'd3, 32'h0000_1020}
        };
        sing = '{
            '{5,  32'h0001_2345},
            '{0,  32'h8000_0001},
            '{15, 32'hFFFF_FFFE},
            '{9,  32'h5A5A_A5A5}
        };

        bus.address   = '0;
        bus.read      = 1'b0;
        bus.write     = 1'b0;
        bus.writedata = '0;
        do_reset();

        // Reset state and register map
        check("reset irq", {31'h0, irq}, 32'h0);
        check("waitrequest", {31'h0, bus.waitrequest}, 32'h0);
        for (int i = 0; i < 4; i++) begin
            peek(reg_tbl[i].addr, d);
            check($sformatf("reset addr%0d", reg_tbl[i].addr), d, reg_tbl[i].exp);
        end
        // Reading head while empty must not pop or underflow
        bus.address = 2'd1;
        bus.read    = 1'b1;
        tick();
        bus.read = 1'b0;
        peek(2'd0, d);
        check("empty read status", d, 32'h0000_0000);

        // Single-channel events: latency, status and pop
        for (int i = 0; i < 4; i++) begin
            set_val(sing[i].ch, sing[i].value);
            data_available[sing[i].ch] = 1'b1;
            e.id    = 4'(sing[i].ch);
            e.value = sing[i].value;
            exp_q.push_back(e);
            tick();
            check($sformatf("single ch%0d irq T+1", sing[i].ch), {31'h0, irq}, 32'h0);
            data_available[sing[i].ch] = 1'b0;
            tick();
            check($sformatf("single ch%0d irq T+2", sing[i].ch), {31'h0, irq}, 32'h1);
            peek(2'd0, d);
            check($sformatf("single ch%0d status", sing[i].ch), d, {16'h0001, 12'h0, 4'(sing[i].ch)});
            pop_check($sformatf("single ch%0d", sing[i].ch));
            check($sformatf("single ch%0d irq after pop", sing[i].ch), {31'h0, irq}, 32'h0);
        end

        // Simultaneous edges 3, 0, 15 with rr_ptr = 0: order 0, 3, 15
        do_reset();
        set_val(3, 32'h0303_0303);
        set_val(0, 32'h0000_00A0);
        set_val(15, 32'h1515_1515);
        data_available = 16'h8009;
        exp_q.push_back('{4'd0, 32'h0000_00A0});
        exp_q.push_back('{4'd3, 32'h0303_0303});
        exp_q.push_back('{4'd15, 32'h1515_1515});
        tick();
        data_available = '0;
        tick();
        tick();
        tick();
        peek(2'd0, d);
        check("rr triple status", d, 32'h0003_0000);
        // rr_ptr must be back at 0: ch0 wins over ch15 only from there
        set_val(0, 32'h0000_00B0);
        set_val(15, 32'h1515_B0B0);
        data_available = 16'h8001;
        exp_q.push_back('{4'd0, 32'h0000_00B0});
        exp_q.push_back('{4'd15, 32'h1515_B0B0});
        tick();
        data_available = '0;
        tick();
        tick();
        tick();
        drain("rr order");

        // 33 distinct edges without reads: the 33rd push is dropped
        for (int c = 0; c < 33; c++) begin
            set_val(c % 16, 32'hA000_0000 + 32'(c));
            data_available = 16'(1) << (c % 16);
            if (c < 32) begin
                exp_q.push_back('{4'(c % 16), 32'hA000_0000 + 32'(c)});
            end
            tick();
        end
        data_available = '0;
        tick();
        tick();
        peek(2'd0, d);
        check("full status", d, 32'h8020_0000);
        peek(2'd2, d);
        check("full drop_count", d, 32'h0000_0001);
        check("full irq", {31'h0, irq}, 32'h1);

        // Full FIFO: pop and grant in the same cycle keeps level at 32, no drop
        set_val(5, 32'hC0FF_EE05);
        data_available[5] = 1'b1;
        tick();
        data_available[5] = 1'b0;
        pop_check("full pop+push");
        exp_q.push_back('{4'd5, 32'hC0FF_EE05});
        peek(2'd0, d);
        check("pop+push status", d, 32'h8020_0001);
        peek(2'd2, d);
        check("pop+push drop_count", d, 32'h0000_0001);
        pop_check("after full 1");
        pop_check("after full 2");
        pop_check("after full 3");

        // Reset mid-burst discards everything; a later edge queues normally
        set_val(1, 32'h1111_0001);
        set_val(2, 32'h2222_0002);
        data_available = 16'h0006;
        tick();
        reset_n        = 1'b0;
        data_available = '0;
        tick();
        reset_n = 1'b1;
        exp_q.delete();
        check("midreset irq", {31'h0, irq}, 32'h0);
        peek(2'd0, d);
        check("midreset status", d, 32'h0000_0000);
        peek(2'd1, d);
        check("midreset head", d, 32'hDEAD_BEEF);
        peek(2'd2, d);
        check("midreset drop_count", d, 32'h0000_0000);
        tick();
        peek(2'd0, d);
        check("midreset no stale push", d, 32'h0000_0000);
        set_val(7, 32'h7777_0007);
        data_available[7] = 1'b1;
        exp_q.push_back('{4'd7, 32'h7777_0007});
        tick();
        data_available[7] = 1'b0;
        tick();
        check("post-reset irq", {31'h0, irq}, 32'h1);
        drain("post-reset");

        // Channel 2 rises twice while blocked behind ch0/ch1; clear in the drop cycle
        set_val(0, 32'h0000_C000);
        set_val(1, 32'h0000_C001);
        set_val(2, 32'hAAAA_0002);
        data_available = 16'h0007;
        exp_q.push_back('{4'd0, 32'h0000_C000});
        exp_q.push_back('{4'd1, 32'h0000_C001});
        exp_q.push_back('{4'd2, 32'hBBBB_0002});
        tick();
        data_available = '0;
        tick();
        set_val(2, 32'hBBBB_0002);
        data_available[2] = 1'b1;
        write_reg(2'd3, 32'h0000_0001);
        tick();
        peek(2'd2, d);
        check("double edge drop_count", d, 32'h0000_0001);
        peek(2'd0, d);
        check("double edge status", d, 32'h8003_0000);
        write_reg(2'd2, 32'h0000_0001);
        write_reg(2'd3, 32'h0000_0002);
        peek(2'd2, d);
        check("ignored writes drop_count", d, 32'h0000_0001);
        write_reg(2'd3, 32'h0000_0001);
        peek(2'd2, d);
        check("clear drop_count", d, 32'h0000_0000);
        peek(2'd0, d);
        check("clear status", d, 32'h0003_0000);
        data_available = '0;
        drain("double edge");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
